mdu: RTL and testbench

Parametrised multi-cycle multiply/divide unit alongside the single-cycle ALU in the execute stage. It performs signed and unsigned multiply and divide into architectural HI/LO registers, and supports direct HI/LO writes. It holds `busy` high for a fixed, parameter-set latency so the hazard unit can stall dependent instructions.

---
 rtl/mdu_pkg.sv | 17 +
 rtl/mdu_arith.sv | 64 ++++++
 rtl/mdu.sv | 114 +++++++++++
 tb/tb_mdu.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared constants for the multiply/divide unit: operation encodings and FSM states.
package mdu_pkg;

  localparam logic [3:0] OpNone  = 4'd0;
  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMthi  = 4'd5;
  localparam logic [3:0] OpMtlo  = 4'd6;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } state_e;

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath; result is {hi, lo}, with a divide-by-zero flag.
module mdu_arith
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [3:0]         i_op,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [2*WIDTH-1:0] o_result,
  output logic               o_div0
);

  localparam logic [WIDTH-1:0] One    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [2*WIDTH-1:0] w_sa;
  logic signed [2*WIDTH-1:0] w_sb;
  logic [2*WIDTH-1:0]        w_sprod;
  logic [2*WIDTH-1:0]        w_uprod;
  logic                      w_bzero;
  logic                      w_sovf;
  logic [WIDTH-1:0]          w_bs;
  logic [WIDTH-1:0]          w_bu;
  logic signed [WIDTH-1:0]   w_sq;
  logic signed [WIDTH-1:0]   w_sr;
  logic [WIDTH-1:0]          w_uq;
  logic [WIDTH-1:0]          w_ur;

  assign w_sa    = {{WIDTH{i_a[WIDTH-1]}}, i_a};
  assign w_sb    = {{WIDTH{i_b[WIDTH-1]}}, i_b};
  assign w_sprod = w_sa * w_sb;
  assign w_uprod = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};

  assign w_bzero = (i_b == '0);
  // MinNeg / -1 wraps to MinNeg rem 0, which is exactly MinNeg / 1.
  assign w_sovf  = (i_a == MinNeg) && (&i_b);
  assign w_bs    = (w_bzero || w_sovf) ? One : i_b;
  assign w_bu    = w_bzero ? One : i_b;

  assign w_sq = $signed(i_a) / $signed(w_bs);
  assign w_sr = $signed(i_a) % $signed(w_bs);
  assign w_uq = i_a / w_bu;
  assign w_ur = i_a % w_bu;

  always_comb begin
    o_result = '0;
    o_div0   = 1'b0;
    case (i_op)
      OpMult:  o_result = w_sprod;
      OpMultu: o_result = w_uprod;
      OpDiv: begin
        o_result = {w_sr, w_sq};
        o_div0   = w_bzero;
      end
      OpDivu: begin
        o_result = {w_ur, w_uq};
        o_div0   = w_bzero;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit: computes at launch, holds busy for a fixed
// latency, then commits the pending result to HI/LO.
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       MDUop,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);
  localparam logic [CntW-1:0] MultLoad = CntW'(MULT_CYCLES);
  localparam logic [CntW-1:0] DivLoad  = CntW'(DIV_CYCLES);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);

  state_e             r_state, w_state_nxt;
  logic [CntW-1:0]    r_cnt, w_cnt_nxt;
  logic [2*WIDTH-1:0] r_pend, w_pend_nxt;
  logic               r_pend_ok, w_pend_ok_nxt;
  logic [WIDTH-1:0]   r_hi, w_hi_nxt;
  logic [WIDTH-1:0]   r_lo, w_lo_nxt;

  logic [2*WIDTH-1:0] w_result;
  logic               w_div0;
  logic               w_done;
  logic               w_accept;

  mdu_arith #(
    .WIDTH(WIDTH)
  ) u_arith (
    .i_op    (MDUop),
    .i_a     (A),
    .i_b     (B),
    .o_result(w_result),
    .o_div0  (w_div0)
  );

  assign w_done = (r_state == StRun) && (r_cnt == CntOne);
  // The completing edge behaves as IDLE so back-to-back ops leave no gap.
  assign w_accept = start && ((r_state == StIdle) || w_done);

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_pend_nxt    = r_pend;
    w_pend_ok_nxt = r_pend_ok;
    w_hi_nxt      = r_hi;
    w_lo_nxt      = r_lo;

    if (r_state == StRun) begin
      w_cnt_nxt = r_cnt - CntOne;
      if (w_done) begin
        w_state_nxt = StIdle;
        if (r_pend_ok) begin
          {w_hi_nxt, w_lo_nxt} = r_pend;
        end
      end
    end

    if (w_accept) begin
      case (MDUop)
        OpMult, OpMultu: begin
          w_state_nxt   = StRun;
          w_cnt_nxt     = MultLoad;
          w_pend_nxt    = w_result;
          w_pend_ok_nxt = 1'b1;
        end
        OpDiv, OpDivu: begin
          w_state_nxt   = StRun;
          w_cnt_nxt     = DivLoad;
          w_pend_nxt    = w_result;
          w_pend_ok_nxt = ~w_div0;
        end
        OpMthi:  w_hi_nxt = A;
        OpMtlo:  w_lo_nxt = A;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_pend    <= '0;
      r_pend_ok <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pend    <= w_pend_nxt;
      r_pend_ok <= w_pend_ok_nxt;
      r_hi      <= w_hi_nxt;
      r_lo      <= w_lo_nxt;
    end
  end

  assign busy = (r_state == StRun);
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for mdu: default 32-bit instance plus a small
// 8-bit instance with overridden latencies.
module tb_mdu;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a, b, hi, lo;
  logic        busy;
  logic        start8;
  logic [3:0]  op8;
  logic [7:0]  a8, b8, hi8, lo8;
  logic        busy8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mdu dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .MDUop(op),
    .A    (a),
    .B    (b),
    .busy (busy),
    .HI   (hi),
    .LO   (lo)
  );

  mdu #(
    .WIDTH      (8),
    .MULT_CYCLES(1),
    .DIV_CYCLES (3)
  ) dut8 (
    .clk  (clk),
    .reset(reset),
    .start(start8),
    .MDUop(op8),
    .A    (a8),
    .B    (b8),
    .busy (busy8),
    .HI   (hi8),
    .LO   (lo8)
  );

  // Present a one-cycle start; returns at the negedge just after the launch edge.
  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = OpNone;
  endtask

  task automatic issue8(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    start8 = 1'b1; op8 = o; a8 = x; b8 = y;
    @(negedge clk);
    start8 = 1'b0; op8 = OpNone;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic count_busy8(output int n);
    n = 0;
    while (busy8 === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: busy=%b HI=%h LO=%h want 0/0/0", busy, hi, lo);
    end
    checks++;
    if (busy8 !== 1'b0 || hi8 !== 8'h0 || lo8 !== 8'h0) begin
      errors++;
      $display("FAIL reset_state8: busy=%b HI=%h LO=%h want 0/0/0", busy8, hi8, lo8);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_mult();
    int n;
    issue(OpMult, 32'hFFFF_FFFF, 32'd2);
    count_busy(n);
    checks++;
    if (n !== 5) begin errors++; $display("FAIL mult_busy: got %0d want 5", n); end
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL mult_result: got %h_%h want ffffffff_fffffffe", hi, lo);
    end
    issue(OpMultu, 32'hFFFF_FFFF, 32'd2);
    count_busy(n);
    checks++;
    if (n !== 5) begin errors++; $display("FAIL multu_busy: got %0d want 5", n); end
    checks++;
    if (hi !== 32'h0000_0001 || lo !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL multu_result: got %h_%h want 00000001_fffffffe", hi, lo);
    end
  endtask

  task automatic test_div();
    int n;
    issue(OpDiv, 32'hFFFF_FFF9, 32'd2);
    count_busy(n);
    checks++;
    if (n !== 10) begin errors++; $display("FAIL div_busy: got %0d want 10", n); end
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
      errors++;
      $display("FAIL div_neg: got HI=%h LO=%h want ffffffff/fffffffd", hi, lo);
    end
    issue(OpDivu, 32'd7, 32'd2);
    count_busy(n);
    checks++;
    if (hi !== 32'd1 || lo !== 32'd3) begin
      errors++;
      $display("FAIL divu_7_2: got HI=%h LO=%h want 1/3", hi, lo);
    end
    issue(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF);
    count_busy(n);
    checks++;
    if (hi !== 32'h0 || lo !== 32'h8000_0000) begin
      errors++;
      $display("FAIL div_ovf: got HI=%h LO=%h want 0/80000000", hi, lo);
    end
  endtask

  task automatic test_div0();
    int n;
    issue(OpMthi, 32'h1234, 32'd0);
    checks++;
    if (hi !== 32'h1234 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mthi: got HI=%h busy=%b want 1234/0", hi, busy);
    end
    issue(OpDivu, 32'd5, 32'd0);
    count_busy(n);
    checks++;
    if (n !== 10) begin errors++; $display("FAIL div0_busy: got %0d want 10", n); end
    checks++;
    if (hi !== 32'h1234 || lo !== 32'h8000_0000) begin
      errors++;
      $display("FAIL div0_keep: got HI=%h LO=%h want 1234/80000000", hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    issue(OpMult, 32'd3, 32'd5);               // now in RUN cycle 1
    @(negedge clk);                            // RUN cycle 2
    start = 1'b1; op = OpMthi; a = 32'hAAAA;
    @(negedge clk);                            // RUN cycle 3
    op = OpDiv; a = 32'd100; b = 32'd7;
    @(negedge clk);                            // RUN cycle 4
    start = 1'b0; op = OpNone;
    checks++;
    if (busy !== 1'b1 || hi !== 32'h1234 || lo !== 32'h8000_0000) begin
      errors++;
      $display("FAIL run_hold: busy=%b HI=%h LO=%h want 1/1234/80000000", busy, hi, lo);
    end
    @(negedge clk);                            // RUN cycle 5, last
    checks++;
    if (busy !== 1'b1 || hi !== 32'h1234) begin
      errors++;
      $display("FAIL run_last: busy=%b HI=%h want 1/1234", busy, hi);
    end
    start = 1'b1; op = OpMultu; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    @(negedge clk);
    start = 1'b0; op = OpNone;
    checks++;
    if (busy !== 1'b1 || hi !== 32'h0 || lo !== 32'd15) begin
      errors++;
      $display("FAIL b2b_commit: busy=%b HI=%h LO=%h want 1/0/f", busy, hi, lo);
    end
    count_busy(n);
    checks++;
    if (n !== 5) begin errors++; $display("FAIL b2b_busy: got %0d want 5", n); end
    checks++;
    if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
      errors++;
      $display("FAIL b2b_result: got %h_%h want fffffffe_00000001", hi, lo);
    end
  endtask

  task automatic test_reset_mid();
    bit bad;
    issue(OpMtlo, 32'h55, 32'd0);
    checks++;
    if (lo !== 32'h55) begin errors++; $display("FAIL mtlo: got %h want 55", lo); end
    issue(OpDiv, 32'd100, 32'd7);              // RUN cycle 1
    @(negedge clk);                            // RUN cycle 2
    @(negedge clk);                            // RUN cycle 3
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b HI=%h LO=%h want 0/0/0", busy, hi, lo);
    end
    @(negedge clk);
    reset = 1'b0;
    bad = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL reset_no_commit: busy=%b HI=%h LO=%h want 0/0/0", busy, hi, lo);
    end
  endtask

  task automatic test_undefined();
    issue(4'd9, 32'hDEAD, 32'd1);
    checks++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      errors++;
      $display("FAIL undef_op: busy=%b HI=%h LO=%h want 0/0/0", busy, hi, lo);
    end
  endtask

  task automatic test_param();
    int n;
    issue8(OpMult, 8'h80, 8'h80);
    count_busy8(n);
    checks++;
    if (n !== 1) begin errors++; $display("FAIL p_mult_busy: got %0d want 1", n); end
    checks++;
    if (hi8 !== 8'h40 || lo8 !== 8'h00) begin
      errors++;
      $display("FAIL p_mult_result: got %h_%h want 40_00", hi8, lo8);
    end
    issue8(OpDivu, 8'd200, 8'd7);
    count_busy8(n);
    checks++;
    if (n !== 3) begin errors++; $display("FAIL p_divu_busy: got %0d want 3", n); end
    checks++;
    if (hi8 !== 8'd4 || lo8 !== 8'd28) begin
      errors++;
      $display("FAIL p_divu_result: got HI=%h LO=%h want 04/1c", hi8, lo8);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0; op = OpNone; a = '0; b = '0;
    start8 = 1'b0; op8 = OpNone; a8 = '0; b8 = '0;
    @(negedge clk);
    test_reset();
    test_mult();
    test_div();
    test_div0();
    test_back_to_back();
    test_reset_mid();
    test_undefined();
    test_param();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
